// File: rtl/link_pkg.sv
// rtl/link_pkg.sv - shared word width, idle sentinel and FSM state type for the link transmit path
package link_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] SENTINEL = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FRAME = 2'd2,
    GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/link_fifo.sv
// rtl/link_fifo.sv - circular synchronous FIFO holding accepted words awaiting transmission
module link_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    pop,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap by natural overflow
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/link_tx_scheduler.sv
// rtl/link_tx_scheduler.sv - round-robin merge of two word sources into a paced serial-link transmitter
module link_tx_scheduler #(
  parameter int                DATA_W       = link_pkg::DATA_W,
  parameter int                DEPTH        = 4,
  parameter int                FRAME_CYCLES = 40,
  parameter int                GAP_CYCLES   = 8,
  parameter logic [DATA_W-1:0] SENTINEL     = link_pkg::SENTINEL
) (
  input  logic                    clk,
  input  logic                    CPU_RESETN,
  input  logic                    req0_valid,
  input  logic [DATA_W-1:0]       req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [DATA_W-1:0]       req1_data,
  output logic                    req1_ready,
  output logic                    tx_start,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [7:0]              drop_count
);

  import link_pkg::*;

  localparam int CNT_MAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              rr_q, rr_d;
  logic [7:0]        drop_q, drop_d;

  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [DATA_W-1:0] fifo_head, acc_data;
  logic              grant0, grant1, accept, is_sentinel;

  // Ready is held low during reset; a full FIFO blocks grants even on a pop cycle
  assign grant0      = CPU_RESETN && !fifo_full && req0_valid && (!req1_valid || !rr_q);
  assign grant1      = CPU_RESETN && !fifo_full && req1_valid && (!req0_valid ||  rr_q);
  assign accept      = grant0 || grant1;
  assign acc_data    = grant0 ? req0_data : req1_data;
  assign is_sentinel = (acc_data == SENTINEL);
  assign fifo_push   = accept && !is_sentinel;
  assign fifo_pop    = (state_q == IDLE) && !fifo_empty;

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign tx_data     = tx_data_q;
  assign drop_count  = drop_q;

  link_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (CPU_RESETN),
    .push    (fifo_push),
    .wr_data (acc_data),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    rr_d   = rr_q;
    drop_d = drop_q;
    if (grant0) begin
      rr_d = 1'b1;
    end else if (grant1) begin
      rr_d = 1'b0;
    end
    if (accept && is_sentinel && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tx_data_q <= '0;
      rr_q      <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      rr_q      <= rr_d;
      drop_q    <= drop_d;
    end
  end

  // Transmitter has no done flag, so frame and gap lengths are counted here
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          tx_data_d = fifo_head;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = CNT_W'(FRAME_CYCLES - 1);
        state_d = FRAME;
      end
      FRAME: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_start = 1'b0;
    busy     = 1'b1;
    case (state_q)
      IDLE:    busy     = 1'b0;
      LOAD:    tx_start = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/link_tx_scheduler.md
Name: link_tx_scheduler

Overview:
- Sits between the two 32-bit word sources (local order entry from the VGA/keyboard front end, and exchange echo/trade-report generator) and the single serial-link transmitter (`communicate`).
- Arbitrates the two requesters round-robin and buffers accepted words in a small FIFO.
- Issues one-cycle start pulses to the transmitter, which has no done/busy output, so frame length and inter-frame gap are timed here.
- Drops the all-ones idle sentinel, which the receiving end discards anyway.

Parameters:
DATA_W, 32, word width carried on the link
DEPTH, 4, FIFO entries (power of 2, >=2)
FRAME_CYCLES, 40, clk cycles the transmitter needs to shift one word out (>=1)
GAP_CYCLES, 8, idle cycles enforced between frames (>=1)
SENTINEL, 32'hFFFF_FFFF, reserved idle pattern, never transmitted

Ports:
clk  in  1  divided system clock (same clock as transmitter)
CPU_RESETN  in  1  asynchronous active-low reset
req0_valid  in  1  local order word available (level)
req0_data  in  DATA_W  local order word
req0_ready  out  1  req0 word accepted this cycle when valid&ready
req1_valid  in  1  echo/report word available (level)
req1_data  in  DATA_W  echo/report word
req1_ready  out  1  req1 word accepted this cycle when valid&ready
tx_start  out  1  one-cycle pulse to transmitter (drives its ready input)
tx_data  out  DATA_W  word to transmit, stable from tx_start through end of FRAME
busy  out  1  high whenever FSM not IDLE
fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
drop_count  out  8  sentinel words accepted-and-discarded, saturates at 255

Behaviour:
- Reset (CPU_RESETN=0, async):
  - tx_start=0, tx_data=0, busy=0, fifo_count=0, drop_count=0, both ready=0.
  - FIFO emptied; rr pointer selects req0.
  - Reset mid-frame aborts the frame with no residual tx_start.
- Arbitration (combinational ready, registered effects):
  - grant only when FIFO not full; full blocks grant even if a pop occurs the same cycle (no bypass).
  - one valid -> that requester granted.
  - both valid -> rr pointer's requester granted; pointer then moves to the other requester.
  - pointer moves only on an accepted handshake.
  - at most one ready high per cycle; ready is never high without the matching valid.
- Sentinel:
  - accepted handshake with data==SENTINEL is not written to the FIFO.
  - drop_count += 1 (saturating); pointer still advances.
- FIFO: circular, wrap at DEPTH; push and pop in the same cycle leave count unchanged.
- FSM:
  - IDLE: if fifo_count>0, pop head into tx_data -> LOAD; else stay.
  - LOAD: tx_start=1 for exactly this cycle; load frame counter=FRAME_CYCLES-1 -> FRAME.
  - FRAME: decrement; at 0, load gap counter=GAP_CYCLES-1 -> GAP.
  - GAP: decrement; at 0 -> IDLE.
  - tx_data held unchanged from the IDLE pop until the next pop.
- Latency:
  - Handshake at edge k into an empty FIFO with idle FSM -> LOAD after edge k+1 -> tx_start high in the cycle between edges k+1 and k+2.
  - Back-to-back start-to-start spacing = FRAME_CYCLES+GAP_CYCLES+2 cycles (50 at defaults).
- Ordering: words transmitted in acceptance order; no reordering across requesters.

Decomposition:
- Package link_pkg: DATA_W, SENTINEL, and FSM state enum {IDLE, LOAD, FRAME, GAP} (2-bit).
- Sub-module link_fifo: sync FIFO with push/pop/full/empty/count, parameterised by DATA_W and DEPTH.
- Arbiter, sentinel filter, FSM and counters stay in the top.

Test Plan:
- Single req0 word 32'h1234_0005 at edge k, idle -> tx_start one cycle after edge k+1, tx_data=32'h1234_0005 held 41 cycles, busy low 50 cycles after LOAD.
- req0 and req1 held valid continuously (distinct data A0,A1,B0,B1...) -> grants alternate req0,req1,req0,...; tx_data sequence A0,B0,A1,B1; tx_start spacing exactly 50 cycles.
- Five words pushed from req0 while the first frame is in flight, DEPTH=4 -> fifo_count reaches 4, req0_ready low while full, first pop re-enables ready; no word lost or duplicated.
- req1 sends SENTINEL then 32'h0000_0007 -> drop_count=1, only 32'h0000_0007 transmitted; 300 sentinels -> drop_count saturates at 255.
- CPU_RESETN pulled low mid-FRAME with 2 words queued -> all outputs 0 asynchronously, fifo_count=0, no tx_start after release until new handshake.
- Push on the same edge as IDLE pops with count=2 -> count stays 2, FIFO order preserved across pointer wrap (10+ words cycled through DEPTH=4).
